// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder slice walks WIDTH bits LSB first.
// Define SERIAL_SUB_EN to add the sub port and A-B operation.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sub_q, sub_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-2:0] sh_q, sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             sub_w;
    logic             x, y, s, co;
    logic [WIDTH-1:0] res;

`ifdef SERIAL_SUB_EN
    assign sub_w = sub;
`else
    assign sub_w = 1'b0;
`endif

    // Single bit slice; B is inverted on the fly for subtraction
    assign x   = a_q[0];
    assign y   = b_q[0] ^ sub_q;
    assign s   = x ^ y ^ carry_q;
    assign co  = (x & y) | (carry_q & (x ^ y));
    assign res = {s, sh_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub_w;
                    carry_d = sub_w ? 1'b1 : c_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    a_d     = a_q >> 1;
                    b_d     = b_q >> 1;
                    sh_d    = res[WIDTH-1:1];
                    carry_d = co;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        sum_d   = res;
                        cout_d  = co;
                        ovf_d   = carry_q ^ co;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sh_q    <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum      = sum_q;
    assign c_out    = cout_q;
    assign overflow = ovf_q;
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized bench for serial_add_ctrl against an arithmetic reference.
// Directed literal cases pin the reference itself.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         c_in = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] sum;
    logic         c_out;
    logic         overflow;
    logic         busy;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    int cyc     = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
`ifdef SERIAL_SUB_EN
        .sub      (sub),
`endif
        .sum      (sum),
        .c_out    (c_out),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    // Reference: whole-word arithmetic plus a cycles-remaining countdown
    int           m_left = 0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_sum = '0, p_sum = '0;
    logic         m_c = 1'b0, m_o = 1'b0, p_c = 1'b0, p_o = 1'b0;

    function automatic logic [W+1:0] ref_op(input logic [W-1:0] ra,
                                            input logic [W-1:0] rb,
                                            input logic rc,
                                            input logic rs);
        logic [W-1:0] bb;
        logic         ci;
        logic [W:0]   full;
        logic         ov;
        bb   = rs ? ~rb : rb;
        ci   = rs ? 1'b1 : rc;
        full = {1'b0, ra} + {1'b0, bb} + {{W{1'b0}}, ci};
        ov   = (ra[W-1] == bb[W-1]) && (full[W-1] != ra[W-1]);
        return {ov, full[W], full[W-1:0]};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        logic [W+1:0] r;
        logic         eff_sub;
        if (!rst_n) begin
            m_left = 0;
            m_done = 1'b0;
            m_sum  = '0;
            m_c    = 1'b0;
            m_o    = 1'b0;
        end else if (m_left > 0) begin
            if (abort) begin
                m_left = 0;
            end else begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_sum  = p_sum;
                    m_c    = p_c;
                    m_o    = p_o;
                    m_done = 1'b1;
                end
            end
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (start) begin
`ifdef SERIAL_SUB_EN
            eff_sub = sub;
`else
            eff_sub = 1'b0;
`endif
            r      = ref_op(a, b, c_in, eff_sub);
            p_sum  = r[W-1:0];
            p_c    = r[W];
            p_o    = r[W+1];
            m_left = W;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_tests++;
            if ({busy, done, sum, c_out, overflow} !==
                {(m_left > 0), m_done, m_sum, m_c, m_o}) begin
                n_fail++;
                $display("FAIL cycle %0d: busy=%b done=%b sum=%h c=%b ov=%b expected busy=%b done=%b sum=%h c=%b ov=%b",
                         cyc, busy, done, sum, c_out, overflow,
                         (m_left > 0), m_done, m_sum, m_c, m_o);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy && !done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("wait_idle timeout", 32'd1, 32'd0);
    endtask

    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ic, input logic is,
                         input logic [W-1:0] es, input logic ec,
                         input logic eo, input string nm);
        int lat;
        int bc;
        wait_idle();
        @(posedge clk);
        #2;
        a = ia; b = ib; c_in = ic; sub = is; start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom);
        c_in = 1'($urandom); sub = 1'($urandom);
        lat = 0;
        bc  = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (busy) bc++;
            if (done) begin
                lat = i;
                break;
            end
        end
        chk({nm, " latency"}, 32'(lat), 32'(W + 1));
        chk({nm, " busy cycles"}, 32'(bc), 32'(W));
        chk({nm, " sum"}, 32'(sum), 32'(es));
        chk({nm, " c_out"}, 32'(c_out), 32'(ec));
        chk({nm, " overflow"}, 32'(overflow), 32'(eo));
    endtask

    initial begin
        int last_done;
        int n_done;
        #2;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset sum", 32'(sum), 32'd0);
        chk("reset c_out", 32'(c_out), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);
        #20;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        do_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "ff+01");
        do_op(8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, "7f+00+1");
`ifdef SERIAL_SUB_EN
        do_op(8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, "10-20");
        do_op(8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, "80-01");
`endif
        do_op(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, "5a+3c");

        // Abort after three RUN cycles leaves the previous result intact
        wait_idle();
        @(posedge clk);
        #2;
        a = 8'h11; b = 8'h22; c_in = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        abort = 1'b1;
        @(posedge clk);
        #2;
        abort = 1'b0;
        @(negedge clk);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort sum kept", 32'(sum), 32'h96);
        repeat (W + 2) begin
            @(negedge clk);
            chk("abort no done", 32'(done), 32'd0);
        end

        // Start held high: one accepted operation per WIDTH+2 cycles
        wait_idle();
        @(posedge clk);
        #2;
        a = 8'h01; b = 8'h02; c_in = 1'b0; sub = 1'b0; start = 1'b1;
        last_done = -1;
        n_done = 0;
        for (int i = 0; i < 4 * (W + 2); i++) begin
            @(negedge clk);
            if (done) begin
                if (last_done >= 0)
                    chk("start period", 32'(i - last_done), 32'(W + 2));
                last_done = i;
                n_done++;
            end
        end
        chk("held-start done count", 32'(n_done), 32'd4);
        chk("held-start sum", 32'(sum), 32'h03);
        @(posedge clk);
        #2;
        start = 1'b0;

        // Asynchronous reset mid-RUN
        wait_idle();
        @(posedge clk);
        #2;
        a = 8'hC3; b = 8'h5E; c_in = 1'b1; start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst sum", 32'(sum), 32'd0);
        chk("async rst c_out", 32'(c_out), 32'd0);
        chk("async rst overflow", 32'(overflow), 32'd0);
        chk("async rst busy", 32'(busy), 32'd0);
        chk("async rst done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        do_op(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, "post-reset 01+01");

        // Random traffic: starts, aborts and operand churn every cycle
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #2;
            start = ($urandom_range(0, 2) == 0);
            abort = ($urandom_range(0, 11) == 0);
            a     = W'($urandom);
            b     = W'($urandom);
            c_in  = 1'($urandom);
            sub   = 1'($urandom);
        end
        @(posedge clk);
        #2;
        start = 1'b0;
        abort = 1'b0;
        repeat (W + 4) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
